// File: rtl/hoops_pkg.sv
// Shared types and constants for the hoop power-up controller.
package hoops_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WAIT_SPAWN,
      ACTIVE,
      EXITING
   } state_t;

   // Galois feedback mask for the 16-bit height generator
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   // Hoop bitmap height in pixels (24-px art scaled x2)
   localparam int HOOP_H = 48;

   // One right-shift Galois step
   function automatic logic [15:0] lfsr_next(input logic [15:0] v);
      return {1'b0, v[15:1]} ^ (v[0] ? LFSR_TAPS : 16'h0000);
   endfunction

endpackage

// File: rtl/hoops_controller_if.sv
// Frame/collision inputs and hoop drawing/scoring outputs of the hoop controller.
interface hoops_controller_if;

   logic               enable;
   logic               startOfFrame;
   logic               rimCollision;
   logic               innerCollision;
   logic signed [10:0] topLeftX;
   logic        [10:0] topLeftY;
   logic               hoopVisible;
   logic               scorePulse;
   logic               rimHitPulse;
   logic               missPulse;
   logic        [7:0]  hoopCount;

   // Controller side
   modport slave (
      input  enable, startOfFrame, rimCollision, innerCollision,
      output topLeftX, topLeftY, hoopVisible, scorePulse, rimHitPulse, missPulse, hoopCount
   );

   // Game/video side
   modport master (
      output enable, startOfFrame, rimCollision, innerCollision,
      input  topLeftX, topLeftY, hoopVisible, scorePulse, rimHitPulse, missPulse, hoopCount
   );

endinterface

// File: rtl/hoops_controller_lfsr16.sv
// Free-running 16-bit Galois LFSR used to pick hoop spawn heights.
module lfsr16
   import hoops_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] seed,
   output logic [15:0] q
);

   // Advance one step every clock; reload the seed on reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q <= seed;
      end else begin
         q <= lfsr_next(q);
      end
   end

endmodule

// File: rtl/hoops_controller.sv
// Hoop power-up sequencer: spawn, per-frame scroll, pass/rim/miss judgement and pass counter.
module hoops_controller
   import hoops_pkg::*;
#(
   parameter int          SCREEN_W     = 640,
   parameter int          HOOP_W       = 48,
   parameter int          SPEED        = 2,
   parameter int          SPAWN_FRAMES = 90,
   parameter int          Y_MIN        = 40,
   parameter logic [15:0] LFSR_SEED    = 16'hACE1
)(
   input  logic           clk,
   input  logic           reset,
   hoops_controller_if.slave bus
);

   localparam logic signed [11:0] STEP      = 12'(SPEED);
   localparam logic signed [11:0] EXIT_X    = 12'(-HOOP_W);
   localparam logic        [7:0]  SPAWN_CNT = 8'(SPAWN_FRAMES);
   localparam logic        [10:0] X_START   = 11'(SCREEN_W);
   localparam logic        [10:0] Y_START   = 11'(Y_MIN);

   state_t             state;
   logic        [7:0]  frame_cnt;
   logic               rim_seen;
   logic               inner_seen;
   logic        [15:0] lfsr_q;
   logic               rim_now;
   logic               inner_now;
   logic signed [11:0] x_next;
   logic               exit_now;

   lfsr16 u_lfsr (
      .clk   (clk),
      .reset (reset),
      .seed  (LFSR_SEED),
      .q     (lfsr_q)
   );

   // Frame evidence including a strobe on the SOF cycle itself; exit test widened to avoid wrap at x=0
   always_comb begin
      rim_now   = rim_seen | bus.rimCollision;
      inner_now = inner_seen | bus.innerCollision;
      x_next    = $signed({bus.topLeftX[10], bus.topLeftX}) - STEP;
      exit_now  = (x_next <= EXIT_X);
   end

   // FSM with registered position, visibility, pulses, collision flags and pass counter
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state           <= IDLE;
         frame_cnt       <= '0;
         rim_seen        <= 1'b0;
         inner_seen      <= 1'b0;
         bus.topLeftX    <= X_START;
         bus.topLeftY    <= Y_START;
         bus.hoopVisible <= 1'b0;
         bus.scorePulse  <= 1'b0;
         bus.rimHitPulse <= 1'b0;
         bus.missPulse   <= 1'b0;
         bus.hoopCount   <= '0;
      end else begin
         bus.scorePulse  <= 1'b0;
         bus.rimHitPulse <= 1'b0;
         bus.missPulse   <= 1'b0;
         if (!bus.enable) begin
            state           <= IDLE;
            bus.hoopVisible <= 1'b0;
            rim_seen        <= 1'b0;
            inner_seen      <= 1'b0;
         end else if (bus.startOfFrame) begin
            rim_seen   <= 1'b0;
            inner_seen <= 1'b0;
            unique case (state)
               IDLE: begin
                  state     <= WAIT_SPAWN;
                  frame_cnt <= SPAWN_CNT;
               end
               WAIT_SPAWN: begin
                  if (frame_cnt == '0) begin
                     bus.topLeftX    <= X_START;
                     bus.topLeftY    <= 11'(16'(Y_MIN) + (lfsr_q & 16'h00FF));
                     bus.hoopVisible <= 1'b1;
                     state           <= ACTIVE;
                  end else begin
                     frame_cnt <= frame_cnt - 8'd1;
                  end
               end
               ACTIVE: begin
                  bus.topLeftX <= x_next[10:0];
                  if (rim_now) begin
                     bus.rimHitPulse <= 1'b1;
                     state           <= EXITING;
                  end else if (inner_now) begin
                     bus.scorePulse <= 1'b1;
                     if (bus.hoopCount != 8'hFF) begin
                        bus.hoopCount <= bus.hoopCount + 8'd1;
                     end
                     state <= EXITING;
                  end else if (exit_now) begin
                     bus.missPulse   <= 1'b1;
                     bus.hoopVisible <= 1'b0;
                     frame_cnt       <= SPAWN_CNT;
                     state           <= WAIT_SPAWN;
                  end
               end
               EXITING: begin
                  bus.topLeftX <= x_next[10:0];
                  if (exit_now) begin
                     bus.hoopVisible <= 1'b0;
                     frame_cnt       <= SPAWN_CNT;
                     state           <= WAIT_SPAWN;
                  end
               end
               default: state <= IDLE;
            endcase
         end else begin
            if (bus.rimCollision) begin
               rim_seen <= 1'b1;
            end
            if (bus.innerCollision) begin
               inner_seen <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_hoops_controller.sv
// Self-checking bench for hoops_controller against a frame-level behavioural model.
module tb_hoops_controller;

   localparam int FL = 5;   // cycles per frame: FL-1 quiet cycles then the SOF cycle

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   hoops_controller_if bus ();
   hoops_controller_if sbus ();

   hoops_controller dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   hoops_controller #(
      .SCREEN_W     (0),
      .SPAWN_FRAMES (1)
   ) dut_sat (
      .clk   (clk),
      .reset (reset),
      .bus   (sbus.slave)
   );

   int checks;
   int errors;

   // Clock edges since reset release = number of LFSR steps taken
   int m_cyc;
   int sof_cyc;
   always @(posedge clk or posedge reset) begin
      if (reset) m_cyc <= 0;
      else       m_cyc <= m_cyc + 1;
   end

   // Frame-level model of the hoop game
   bit m_run, m_alive, m_judged;
   int m_wait, m_x, m_y, m_cnt;
   bit e_score, e_rim, e_miss;

   function automatic logic [15:0] lfsr_after(input int n);
      logic [15:0] v;
      v = 16'hACE1;
      for (int i = 0; i < n; i++) v = (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
      return v;
   endfunction

   task automatic model_reset();
      m_run = 0; m_alive = 0; m_judged = 0;
      m_wait = 0; m_x = 640; m_y = 40; m_cnt = 0;
      e_score = 0; e_rim = 0; e_miss = 0;
   endtask

   task automatic model_sof(input bit rim, input bit inner);
      logic [15:0] r;
      e_score = 0; e_rim = 0; e_miss = 0;
      if (!m_run) begin
         m_run = 1; m_wait = 90;
      end else if (!m_alive) begin
         if (m_wait == 0) begin
            r = lfsr_after(sof_cyc);
            m_alive = 1; m_judged = 0; m_x = 640; m_y = 40 + int'(r[7:0]);
         end else begin
            m_wait--;
         end
      end else begin
         m_x -= 2;
         if (!m_judged && rim) begin
            e_rim = 1; m_judged = 1;
         end else if (!m_judged && inner) begin
            e_score = 1; m_judged = 1;
            if (m_cnt < 255) m_cnt++;
         end else if (m_x <= -48) begin
            e_miss = !m_judged; m_alive = 0; m_wait = 90;
         end
      end
   endtask

   function automatic logic [33:0] obs_vec();
      return {bus.hoopVisible, bus.scorePulse, bus.rimHitPulse, bus.missPulse,
              bus.hoopCount, bus.topLeftX, bus.topLeftY};
   endfunction

   function automatic logic [33:0] exp_vec();
      return {m_alive, e_score, e_rim, e_miss, 8'(m_cnt), 11'(m_x), 11'(m_y)};
   endfunction

   function automatic int rnd_at();
      return ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, FL - 1)) : -1;
   endfunction

   // One frame: strobes at cycle index rim_at/inner_at (-1 = none), SOF last; returns one cycle after SOF
   task automatic run_frame(input int rim_at, input int inner_at);
      for (int c = 0; c < FL; c++) begin
         @(negedge clk);
         bus.startOfFrame   = (c == FL - 1);
         bus.rimCollision   = (c == rim_at);
         bus.innerCollision = (c == inner_at);
         if (c == FL - 1) sof_cyc = m_cyc;
      end
      @(negedge clk);
      bus.startOfFrame = 0; bus.rimCollision = 0; bus.innerCollision = 0;
      if (bus.enable) model_sof(rim_at >= 0, inner_at >= 0);
   endtask

   task automatic wait_spawn();
      for (int f = 0; f < 200 && !m_alive; f++) run_frame(rnd_at(), rnd_at());
   endtask

   task automatic test_reset();
      @(negedge clk);
      if (obs_vec() !== exp_vec()) begin
         errors++; $display("FAIL reset_state: got %h expected %h", obs_vec(), exp_vec());
      end
      checks++;
      for (int f = 0; f < 3; f++) begin
         run_frame(rnd_at(), rnd_at());
         if (obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL idle_disabled: got %h expected %h", obs_vec(), exp_vec());
         end
         checks++;
      end
   endtask

   task automatic test_spawn();
      int frames;
      bus.enable = 1;
      frames = 0;
      while (!bus.hoopVisible && frames < 200) begin
         run_frame(rnd_at(), rnd_at());
         frames++;
         if (obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL spawn_wait: got %h expected %h", obs_vec(), exp_vec());
         end
         checks++;
      end
      if (frames !== 92) begin
         errors++; $display("FAIL spawn_delay: got %0d frames expected 92", frames);
      end
      checks++;
      if (bus.topLeftY < 11'd40 || bus.topLeftY > 11'd295) begin
         errors++; $display("FAIL spawn_y_range: got %0d expected 40..295", bus.topLeftY);
      end
      checks++;
      for (int f = 0; f < 3; f++) begin
         run_frame(-1, -1);
         if (obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL scroll: got %h expected %h", obs_vec(), exp_vec());
         end
         checks++;
      end
   endtask

   task automatic test_score();
      repeat ($urandom_range(0, 15)) run_frame(-1, -1);
      run_frame(-1, int'($urandom_range(0, FL - 2)));
      if (obs_vec() !== exp_vec()) begin
         errors++; $display("FAIL score_pulse: got %h expected %h", obs_vec(), exp_vec());
      end
      checks++;
      @(negedge clk);
      if (bus.scorePulse !== 1'b0) begin
         errors++; $display("FAIL score_width: got %b expected 0", bus.scorePulse);
      end
      checks++;
      for (int f = 0; f < 400 && m_alive; f++) begin
         run_frame(rnd_at(), rnd_at());
         if (obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL score_flight: got %h expected %h", obs_vec(), exp_vec());
         end
         checks++;
      end
   endtask

   task automatic test_rim_and_inner();
      wait_spawn();
      repeat ($urandom_range(0, 10)) run_frame(-1, -1);
      run_frame(int'($urandom_range(0, FL - 1)), int'($urandom_range(0, FL - 1)));
      if (obs_vec() !== exp_vec()) begin
         errors++; $display("FAIL rim_wins: got %h expected %h", obs_vec(), exp_vec());
      end
      checks++;
      for (int f = 0; f < 400 && m_alive; f++) begin
         run_frame(rnd_at(), rnd_at());
         if (obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL rim_flight: got %h expected %h", obs_vec(), exp_vec());
         end
         checks++;
      end
   endtask

   task automatic test_miss();
      int last_x;
      bit saw_miss;
      wait_spawn();
      last_x = 9999; saw_miss = 0;
      for (int f = 0; f < 400 && m_alive; f++) begin
         run_frame(-1, -1);
         if (bus.hoopVisible) last_x = int'(bus.topLeftX);
         if (bus.missPulse)   saw_miss = 1;
         if (obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL miss_flight: got %h expected %h", obs_vec(), exp_vec());
         end
         checks++;
      end
      if (last_x != -46 || !saw_miss) begin
         errors++; $display("FAIL miss_edge: got last_x=%0d miss=%b expected last_x=-46 miss=1", last_x, saw_miss);
      end
      checks++;
   endtask

   task automatic test_coincident();
      wait_spawn();
      repeat ($urandom_range(0, 10)) run_frame(-1, -1);
      run_frame(-1, FL - 1);
      if (obs_vec() !== exp_vec()) begin
         errors++; $display("FAIL sof_coincident: got %h expected %h", obs_vec(), exp_vec());
      end
      checks++;
      for (int f = 0; f < 400 && m_alive; f++) run_frame(-1, -1);
      if (obs_vec() !== exp_vec()) begin
         errors++; $display("FAIL coincident_exit: got %h expected %h", obs_vec(), exp_vec());
      end
      checks++;
   endtask

   task automatic test_enable_drop();
      wait_spawn();
      repeat ($urandom_range(1, 5)) run_frame(-1, -1);
      @(negedge clk);
      bus.enable = 0;
      @(negedge clk);
      m_run = 0; m_alive = 0; e_score = 0; e_rim = 0; e_miss = 0;
      if (obs_vec() !== exp_vec()) begin
         errors++; $display("FAIL enable_drop: got %h expected %h", obs_vec(), exp_vec());
      end
      checks++;
      for (int f = 0; f < 3; f++) begin
         run_frame(rnd_at(), rnd_at());
         if (obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL disabled_hold: got %h expected %h", obs_vec(), exp_vec());
         end
         checks++;
      end
      bus.enable = 1;
   endtask

   task automatic test_reset_mid();
      wait_spawn();
      repeat ($urandom_range(1, 5)) run_frame(-1, -1);
      @(negedge clk);
      bus.innerCollision = 1;
      @(negedge clk);
      bus.innerCollision = 0;
      reset = 1;
      #1;
      model_reset();
      if (obs_vec() !== exp_vec()) begin
         errors++; $display("FAIL reset_mid: got %h expected %h", obs_vec(), exp_vec());
      end
      checks++;
      @(negedge clk);
      reset = 0;
      for (int f = 0; f < 3; f++) begin
         run_frame(-1, -1);
         if (obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL after_reset: got %h expected %h", obs_vec(), exp_vec());
         end
         checks++;
      end
   endtask

   task automatic test_saturate();
      int passes;
      int want;
      passes = 0;
      sbus.enable = 1;
      sbus.innerCollision = 1;
      for (int c = 0; c < 40000 && passes < 260; c++) begin
         @(negedge clk);
         if (sbus.scorePulse) begin
            passes++;
            want = (passes > 255) ? 255 : passes;
            if (sbus.hoopCount !== 8'(want)) begin
               errors++; $display("FAIL sat_count: got %0d expected %0d", sbus.hoopCount, want);
            end
            checks++;
         end
         sbus.startOfFrame = (c % 2 == 0);
      end
      sbus.startOfFrame = 0;
      if (passes != 260) begin
         errors++; $display("FAIL sat_timeout: got %0d passes expected 260", passes);
      end
      checks++;
      if (sbus.hoopCount !== 8'd255) begin
         errors++; $display("FAIL sat_final: got %0d expected 255", sbus.hoopCount);
      end
      checks++;
   endtask

   initial begin
      checks = 0; errors = 0;
      reset = 1;
      bus.enable = 0; bus.startOfFrame = 0; bus.rimCollision = 0; bus.innerCollision = 0;
      sbus.enable = 0; sbus.startOfFrame = 0; sbus.rimCollision = 0; sbus.innerCollision = 0;
      model_reset();
      repeat (3) @(negedge clk);
      reset = 0;
      test_reset();
      test_spawn();
      test_score();
      test_rim_and_inner();
      test_miss();
      test_coincident();
      test_enable_drop();
      test_reset_mid();
      test_saturate();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
